ir_debounce: RTL and testbench

Two-channel conditioner for the board's external IR sensors; it sits between the raw sensor pins (D13, D12) and the LEDs or any downstream consumer. Each channel:
- synchronises the asynchronous sensor level into the clock domain;
- rejects glitches shorter than a programmable window;
- publishes the filtered level, one-cycle edge pulses and a detection counter.

It replaces the direct pin-to-LED wiring, so LED0/LED1 show clean, debounced sensor state.

---
 rtl/ir_debounce.sv | 91 +++++++++
 tb/tb_ir_debounce.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_debounce.sv
// rtl/ir_debounce.sv - two-channel IR sensor synchroniser, debouncer and rising-edge counter
module ir_debounce #(
   parameter int DEB_CYCLES = 120000
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic       D13,
   input  logic       D12,
   input  logic       CLR,
   output logic       LED0,
   output logic       LED1,
   output logic       RISE0,
   output logic       RISE1,
   output logic       FALL0,
   output logic       FALL1,
   output logic [7:0] CNT0,
   output logic [7:0] CNT1
);

   // Debounce counter only needs to reach DEB_CYCLES-1; keep at least one bit.
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DC_MAX = DW'(DEB_CYCLES - 1);

   // Bit 0 is channel 0 (D13), bit 1 is channel 1 (D12).
   logic [1:0]          raw;
   logic [1:0]          s1;
   logic [1:0]          s2;
   logic [1:0]          st;
   logic [1:0]          rise;
   logic [1:0]          fall;
   logic [1:0]          accept;
   logic [1:0][DW-1:0]  dc;
   logic [1:0][7:0]     cnt;

   assign raw = {D12, D13};

   // A channel accepts its synchronised level once it has disagreed with st for DEB_CYCLES edges.
   always_comb begin
      accept = '0;
      for (int i = 0; i < 2; i++) begin
         accept[i] = (s2[i] != st[i]) && (dc[i] == DC_MAX);
      end
   end

   // Synchronise, debounce, emit one-cycle edge pulses and count accepted rising edges.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s1   <= '0;
         s2   <= '0;
         st   <= '0;
         rise <= '0;
         fall <= '0;
         dc   <= '0;
         cnt  <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            rise[i] <= 1'b0;
            fall[i] <= 1'b0;
            if (s2[i] == st[i]) begin
               // Any return to the stable level discards the partial mismatch run.
               dc[i] <= '0;
            end else if (!accept[i]) begin
               dc[i] <= dc[i] + 1'b1;
            end else begin
               st[i]   <= s2[i];
               dc[i]   <= '0;
               rise[i] <= s2[i];
               fall[i] <= ~s2[i];
            end
            // Clear takes priority over a rising edge accepted on the same edge.
            if (CLR) begin
               cnt[i] <= '0;
            end else if (accept[i] && s2[i]) begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign LED0  = st[0];
   assign LED1  = st[1];
   assign RISE0 = rise[0];
   assign RISE1 = rise[1];
   assign FALL0 = fall[0];
   assign FALL1 = fall[1];
   assign CNT0  = cnt[0];
   assign CNT1  = cnt[1];

endmodule

// File: tb/tb_ir_debounce.sv
// tb/tb_ir_debounce.sv - directed self-checking bench for ir_debounce with DEB_CYCLES=4
module tb_ir_debounce;

   logic       CLK;
   logic       RSTN;
   logic       D13;
   logic       D12;
   logic       CLR;
   logic       LED0;
   logic       LED1;
   logic       RISE0;
   logic       RISE1;
   logic       FALL0;
   logic       FALL1;
   logic [7:0] CNT0;
   logic [7:0] CNT1;

   int errors = 0;
   int checks = 0;

   ir_debounce #(.DEB_CYCLES(4)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .D13   (D13),
      .D12   (D12),
      .CLR   (CLR),
      .LED0  (LED0),
      .LED1  (LED1),
      .RISE0 (RISE0),
      .RISE1 (RISE1),
      .FALL0 (FALL0),
      .FALL1 (FALL1),
      .CNT0  (CNT0),
      .CNT1  (CNT1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
   task automatic tick(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RSTN = 1'b0;
      D13  = 1'b0;
      D12  = 1'b0;
      CLR  = 1'b0;
      tick(2);
      RSTN = 1'b1;
      tick(8);
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      D13  = 1'b1;
      D12  = 1'b1;
      CLR  = 1'b0;
      tick(3);
      checks++;
      if ({LED0, LED1} !== 2'b00) begin
         errors++;
         $display("FAIL reset_led: got %b%b expected 00", LED0, LED1);
      end
      checks++;
      if ({CNT0, CNT1} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d expected 0/0", CNT0, CNT1);
      end
      checks++;
      if ({RISE0, RISE1, FALL0, FALL1} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_pulses: got %b expected 0000", {RISE0, RISE1, FALL0, FALL1});
      end
      RSTN = 1'b1;
      tick(5);
      checks++;
      if ({LED0, LED1} !== 2'b00) begin
         errors++;
         $display("FAIL reset_early: got %b%b expected 00 after 5 edges", LED0, LED1);
      end
      tick(1);
      checks++;
      if ({LED0, LED1, RISE0, RISE1} !== 4'b1111) begin
         errors++;
         $display("FAIL reset_rise: got %b expected 1111 after 6 edges", {LED0, LED1, RISE0, RISE1});
      end
      checks++;
      if (CNT0 !== 8'd1 || CNT1 !== 8'd1) begin
         errors++;
         $display("FAIL reset_cnt1: got %0d/%0d expected 1/1", CNT0, CNT1);
      end
      tick(1);
      checks++;
      if ({RISE0, RISE1, LED0, LED1} !== 4'b0011) begin
         errors++;
         $display("FAIL reset_pulse_width: got %b expected 0011", {RISE0, RISE1, LED0, LED1});
      end
   endtask

   task automatic test_glitch();
      int saw;
      do_reset();
      saw = 0;
      D13 = 1'b1;
      tick(3);
      D13 = 1'b0;
      for (int j = 0; j < 10; j++) begin
         tick(1);
         if (LED0 !== 1'b0 || RISE0 !== 1'b0) saw++;
      end
      checks++;
      if (saw !== 0) begin
         errors++;
         $display("FAIL glitch_reject: got %0d bad cycles expected 0", saw);
      end
      checks++;
      if (CNT0 !== 8'd0) begin
         errors++;
         $display("FAIL glitch_cnt: got %0d expected 0", CNT0);
      end
      D13 = 1'b1;
      tick(4);
      D13 = 1'b0;
      tick(2);
      checks++;
      if ({LED0, RISE0} !== 2'b11 || CNT0 !== 8'd1) begin
         errors++;
         $display("FAIL glitch_accept4: got led=%b rise=%b cnt=%0d expected 1 1 1", LED0, RISE0, CNT0);
      end
      tick(10);
   endtask

   task automatic test_falling_edge();
      int falls;
      int fall_at;
      do_reset();
      D12 = 1'b1;
      tick(10);
      checks++;
      if (LED1 !== 1'b1 || CNT1 !== 8'd1) begin
         errors++;
         $display("FAIL fall_setup: got led1=%b cnt1=%0d expected 1 1", LED1, CNT1);
      end
      falls   = 0;
      fall_at = 0;
      D12 = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         tick(1);
         if (FALL1 === 1'b1) begin
            falls++;
            fall_at = j;
         end
      end
      checks++;
      if (falls !== 1 || fall_at !== 6) begin
         errors++;
         $display("FAIL fall_pulse: got %0d pulses at edge %0d expected 1 at edge 6", falls, fall_at);
      end
      checks++;
      if (LED1 !== 1'b0 || CNT1 !== 8'd1) begin
         errors++;
         $display("FAIL fall_state: got led1=%b cnt1=%0d expected 0 1", LED1, CNT1);
      end
   endtask

   task automatic test_wrap_clear();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         D13 = 1'b1;
         tick(8);
         D13 = 1'b0;
         tick(8);
         if (i == 254) begin
            checks++;
            if (CNT0 !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: got %0d expected 255", CNT0);
            end
         end
      end
      checks++;
      if (CNT0 !== 8'd0 || CNT1 !== 8'd0) begin
         errors++;
         $display("FAIL wrap_zero: got %0d/%0d expected 0/0", CNT0, CNT1);
      end
      D13 = 1'b1;
      tick(8);
      D13 = 1'b0;
      tick(8);
      checks++;
      if (CNT0 !== 8'd1) begin
         errors++;
         $display("FAIL wrap_next: got %0d expected 1", CNT0);
      end
      // Clear coincident with acceptance edge.
      D13 = 1'b1;
      tick(5);
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      checks++;
      if (RISE0 !== 1'b1 || CNT0 !== 8'd0) begin
         errors++;
         $display("FAIL clear_wins: got rise=%b cnt=%0d expected 1 0", RISE0, CNT0);
      end
      D13 = 1'b0;
      tick(8);
      // Clear asserted during the RISE0 cycle.
      D13 = 1'b1;
      tick(6);
      checks++;
      if (RISE0 !== 1'b1 || CNT0 !== 8'd1) begin
         errors++;
         $display("FAIL clear_pre: got rise=%b cnt=%0d expected 1 1", RISE0, CNT0);
      end
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      checks++;
      if (CNT0 !== 8'd0) begin
         errors++;
         $display("FAIL clear_rise_cycle: got %0d expected 0", CNT0);
      end
      D13 = 1'b0;
      tick(8);
   endtask

   task automatic test_mid_reset();
      do_reset();
      D13 = 1'b1;
      tick(3);
      RSTN = 1'b0;
      tick(1);
      RSTN = 1'b1;
      tick(5);
      checks++;
      if (LED0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_early: got %b expected 0 after 5 edges", LED0);
      end
      tick(1);
      checks++;
      if (LED0 !== 1'b1 || RISE0 !== 1'b1) begin
         errors++;
         $display("FAIL midreset_rise: got led=%b rise=%b expected 1 1", LED0, RISE0);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      D13 = 1'b1;
      D12 = 1'b1;
      tick(5);
      checks++;
      if ({RISE0, RISE1} !== 2'b00) begin
         errors++;
         $display("FAIL simul_early: got %b expected 00", {RISE0, RISE1});
      end
      tick(1);
      checks++;
      if ({RISE0, RISE1} !== 2'b11) begin
         errors++;
         $display("FAIL simul_rise: got %b expected 11", {RISE0, RISE1});
      end
      checks++;
      if (CNT0 !== 8'd1 || CNT1 !== 8'd1) begin
         errors++;
         $display("FAIL simul_cnt: got %0d/%0d expected 1/1", CNT0, CNT1);
      end
   endtask

   initial begin
      RSTN = 1'b0;
      D13  = 1'b0;
      D12  = 1'b0;
      CLR  = 1'b0;
      test_reset();
      test_glitch();
      test_falling_edge();
      test_wrap_clear();
      test_mid_reset();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
